key_event_arbiter: RTL

Collects asynchronous key inputs from N board keys and synchronizes each one. A release (press-then-release) on any key becomes a one-shot event. Pending events are shared with a single downstream consumer through round-robin arbitration and a valid/ready handshake, so exactly one key ID is offered at a time. The block sits between the raw KEY pins and the control FSMs that consume key commands, and replaces per-key ad-hoc edge detectors.

---
 rtl/key_event_arbiter_if.sv | 13 +
 rtl/key_event_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter_if.sv
// Event handshake bundle between key_event_arbiter (master) and its consumer (slave).
interface key_event_arbiter_if #(
  parameter int N_KEYS = 4
) ();
  localparam int ID_W = $clog2(N_KEYS);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/key_event_arbiter.sv
// Synchronizes N raw keys, turns each release into a one-shot event and offers pending events
// round-robin over a valid/ready handshake. Define KEY_REPEAT_EN to add hold-to-repeat events.
module key_event_arbiter #(
  parameter int N_KEYS        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_KEYS-1:0]   key_i,
  key_event_arbiter_if.master evt,
  output logic                evt_overflow_o,
  output logic [N_KEYS-1:0]   pending_o
);

  localparam int ID_W = $clog2(N_KEYS);

  if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_n_keys
    $error("key_event_arbiter: N_KEYS must be in 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_event_arbiter: SYNC_STAGES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("key_event_arbiter: REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [N_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [N_KEYS-1:0] prev_q;
  logic [N_KEYS-1:0] sync_level;
  logic [N_KEYS-1:0] rel;
  logic [N_KEYS-1:0] evt_set;
  logic [N_KEYS-1:0] clr_vec;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              handshake;

  state_t            state_q;
  logic              evt_valid_q;
  logic [ID_W-1:0]   evt_id_q;
  logic [ID_W-1:0]   last_grant_q;
  logic              found;
  logic [ID_W-1:0]   pick;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int st = 0; st < SYNC_STAGES; st++) begin
        sync_q[st] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= key_i;
      for (int st = 1; st < SYNC_STAGES; st++) begin
        sync_q[st] <= sync_q[st-1];
      end
      prev_q <= sync_level;
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign rel        = prev_q & ~sync_level;

`ifdef KEY_REPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0]  hold_q [N_KEYS];
  logic [N_KEYS-1:0] rpt;

  // A held key fires once every REPEAT_CYCLES cycles; releasing it zeroes the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_KEYS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (!sync_level[k] || hold_q[k] == CNT_LAST) begin
          hold_q[k] <= '0;
        end else begin
          hold_q[k] <= hold_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      rpt[k] = sync_level[k] && (hold_q[k] == CNT_LAST);
    end
  end

  assign evt_set = rel | rpt;
`else
  assign evt_set = rel;
`endif

  assign handshake = evt_valid_q & evt.evt_ready;
  assign clr_vec   = handshake ? (N_KEYS'(1) << evt_id_q) : '0;

  // A new event landing on its own clear cycle survives; one landing on a busy slot is lost.
  always_comb begin
    pending_d  = (pending_q & ~clr_vec) | evt_set;
    overflow_d = overflow_q | (|(evt_set & pending_q & ~clr_vec));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_KEYS; k++) begin
      idx = (int'(last_grant_q) + k) % N_KEYS;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Offered ID stays frozen in OFFER until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_KEYS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            evt_id_q    <= pick;
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            last_grant_q <= evt_id_q;
            evt_valid_q  <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_id     = evt_id_q;
  assign evt_overflow_o = overflow_q;
  assign pending_o      = pending_q;

endmodule
